// File: rtl/pulse_length_pkg.sv
// Shared definitions for the pulse length meter: default sizing and FSM state encodings.
package pulse_length_pkg;

    // Default width of the measured length and of the internal counter.
    localparam int DEFAULT_LENGTH_BITS = 5;

    // Default depth of the input synchronizer chain.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } meter_state_e;

endpackage : pulse_length_pkg

// File: rtl/pulse_input_synchronizer.sv
// Multi-flop synchronizer for an asynchronous input. Besides the synchronized
// level it reports when the chain holds only real post-reset samples, so the
// consumer can tell a genuine level from the reset value of the flops.
module pulse_input_synchronizer
    import pulse_length_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic sync_valid
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic [SYNC_STAGES-1:0] stage_d;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [SYNC_STAGES-1:0] fill_d;

    // Shift the raw input and a "sample is real" marker down the chain.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        stage_d    = '0;
        fill_d     = '0;
        stage_d[0] = async_in;
        fill_d[0]  = 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
            fill_d[i]  = fill_q[i-1];
        end
    end

    // Register the chain; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_n) begin
            stage_q <= '0;
            fill_q  <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    assign sync_out   = stage_q[SYNC_STAGES-1];
    assign sync_valid = fill_q[SYNC_STAGES-1];

endmodule : pulse_input_synchronizer

// File: rtl/pulse_length_meter.sv
// Measures the high time of an asynchronous pulse in clock cycles and presents
// the result with a valid/ready handshake. Rising edges that arrive while a
// result is still pending are flagged as dropped and never measured.
module pulse_length_meter
    import pulse_length_pkg::*;
#(
    parameter int DEEP_PULSE_LENGTH_BITS = DEFAULT_LENGTH_BITS,
    parameter int SYNC_STAGES            = DEFAULT_SYNC_STAGES
) (
    input  logic                              IN_CLOCK,
    input  logic                              IN_RESET_N,
    input  logic                              IN_PULSE,
    input  logic                              IN_READY,
    output logic [DEEP_PULSE_LENGTH_BITS-1:0] OUT_PULSE_LENGTH_CLKS,
    output logic                              OUT_VALID,
    output logic                              OUT_OVERFLOW,
    output logic                              OUT_DROPPED
);

    localparam logic [DEEP_PULSE_LENGTH_BITS-1:0] COUNT_MAX = '1;
    localparam logic [DEEP_PULSE_LENGTH_BITS-1:0] COUNT_ONE = DEEP_PULSE_LENGTH_BITS'(1);

    logic pulse_s;
    logic pulse_s_vld;
    logic pulse_q;
    logic rise;

    // Armed once a real low level has been seen after reset, so a pulse that
    // is already high when reset releases never looks like a rising edge.
    logic armed_q;
    logic armed_d;

    meter_state_e                      state_q;
    meter_state_e                      state_d;
    logic [DEEP_PULSE_LENGTH_BITS-1:0] count_q;
    logic [DEEP_PULSE_LENGTH_BITS-1:0] count_d;
    logic                              ovf_q;
    logic                              ovf_d;
    logic [DEEP_PULSE_LENGTH_BITS-1:0] length_q;
    logic [DEEP_PULSE_LENGTH_BITS-1:0] length_d;
    logic                              valid_q;
    logic                              valid_d;
    logic                              overflow_q;
    logic                              overflow_d;
    logic                              dropped_q;
    logic                              dropped_d;

    pulse_input_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (IN_CLOCK),
        .rst_n      (IN_RESET_N),
        .async_in   (IN_PULSE),
        .sync_out   (pulse_s),
        .sync_valid (pulse_s_vld)
    );

    assign rise    = armed_q & pulse_s & ~pulse_q;
    assign armed_d = armed_q | (pulse_s_vld & ~pulse_s);

    // Next-state, counter and result-register logic of the measurement FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        length_d   = length_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        case (state_q)
            ST_IDLE: begin
                // The first high sample is counted on the edge that sees the rise.
                if (rise) begin
                    state_d = ST_MEASURE;
                    count_d = COUNT_ONE;
                    ovf_d   = 1'b0;
                end
            end

            ST_MEASURE: begin
                if (pulse_s) begin
                    if (count_q == COUNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    state_d    = ST_REPORT;
                    length_d   = count_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                end
            end

            ST_REPORT: begin
                if (IN_READY) begin
                    // Handshake: release the result; a rise on this very edge
                    // is still reported as dropped.
                    state_d    = ST_IDLE;
                    valid_d    = 1'b0;
                    overflow_d = 1'b0;
                    dropped_d  = rise;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                end else begin
                    dropped_d = dropped_q | rise;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and registered outputs; synchronous active-low reset.
    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET_N) begin
            pulse_q    <= 1'b0;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            length_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            pulse_q    <= pulse_s;
            armed_q    <= armed_d;
            state_q    <= state_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            length_q   <= length_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    assign OUT_PULSE_LENGTH_CLKS = length_q;
    assign OUT_VALID             = valid_q;
    assign OUT_OVERFLOW          = overflow_q;
    assign OUT_DROPPED           = dropped_q;

endmodule : pulse_length_meter

// File: tb/tb_pulse_length_meter.sv
// Self-checking bench for pulse_length_meter: expected results are queued as
// pulses are driven and compared when OUT_VALID rises; directed checks cover
// reset, handshake hold, dropped pulses and saturation.
module tb_pulse_length_meter;

    localparam int W        = 5;
    localparam int S        = 2;
    localparam int MAX_LEN  = (1 << W) - 1;

    typedef struct {
        int len;
        bit ovf;
        bit drp;
        int cyc;
    } exp_t;

    logic         IN_CLOCK;
    logic         IN_RESET_N;
    logic         IN_PULSE;
    logic         IN_READY;
    logic [W-1:0] OUT_PULSE_LENGTH_CLKS;
    logic         OUT_VALID;
    logic         OUT_OVERFLOW;
    logic         OUT_DROPPED;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   prev_valid = 1'b0;

    pulse_length_meter #(
        .DEEP_PULSE_LENGTH_BITS (W),
        .SYNC_STAGES            (S)
    ) dut (
        .IN_CLOCK              (IN_CLOCK),
        .IN_RESET_N            (IN_RESET_N),
        .IN_PULSE              (IN_PULSE),
        .IN_READY              (IN_READY),
        .OUT_PULSE_LENGTH_CLKS (OUT_PULSE_LENGTH_CLKS),
        .OUT_VALID             (OUT_VALID),
        .OUT_OVERFLOW          (OUT_OVERFLOW),
        .OUT_DROPPED           (OUT_DROPPED)
    );

    // 50 MHz clock.
    initial IN_CLOCK = 1'b0;
    always #10 IN_CLOCK = ~IN_CLOCK;

    // Count rising edges so result latency can be checked.
    always @(posedge IN_CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive a pulse starting at the current negedge: 'hi' high samples then
    // 'lo' low samples. When 'measured' is set the expected result is queued.
    task automatic drive_pulse(input int hi, input int lo, input bit measured, output int low_edge);
        exp_t e;
        IN_PULSE = 1'b1;
        repeat (hi) @(negedge IN_CLOCK);
        IN_PULSE = 1'b0;
        low_edge = cyc + 1;
        if (measured) begin
            e.len = (hi > MAX_LEN) ? MAX_LEN : hi;
            e.ovf = (hi > MAX_LEN);
            e.drp = 1'b0;
            e.cyc = low_edge + S;
            sb_q.push_back(e);
        end
        repeat (lo) @(negedge IN_CLOCK);
    endtask

    // Compare each new result against the head of the scoreboard.
    always @(negedge IN_CLOCK) begin
        if (OUT_VALID === 1'b1 && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(OUT_VALID), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("length",   32'(OUT_PULSE_LENGTH_CLKS), 32'(mon_e.len));
                check("overflow", 32'(OUT_OVERFLOW),          32'(mon_e.ovf));
                check("dropped",  32'(OUT_DROPPED),           32'(mon_e.drp));
                check("latency",  32'(cyc),                   32'(mon_e.cyc));
            end
        end
        prev_valid = (OUT_VALID === 1'b1);
    end

    // Hard stop in case something never terminates.
    initial begin
        #400_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low;
        int sweep[5] = '{1, 3, 5, 7, 9};

        IN_PULSE   = 1'b0;
        IN_READY   = 1'b1;
        IN_RESET_N = 1'b0;
        repeat (3) @(negedge IN_CLOCK);
        check("reset_len",      32'(OUT_PULSE_LENGTH_CLKS), 32'd0);
        check("reset_valid",    32'(OUT_VALID),             32'd0);
        check("reset_overflow", 32'(OUT_OVERFLOW),          32'd0);
        check("reset_dropped",  32'(OUT_DROPPED),           32'd0);
        IN_RESET_N = 1'b1;
        repeat (5) @(negedge IN_CLOCK);

        // 7-clock pulse: one-cycle OUT_VALID two edges after the first low sample.
        drive_pulse(7, 0, 1'b1, low);
        repeat (3) @(negedge IN_CLOCK);
        check("valid_high",      32'(OUT_VALID), 32'd1);
        @(negedge IN_CLOCK);
        check("valid_one_cycle", 32'(OUT_VALID), 32'd0);
        repeat (4) @(negedge IN_CLOCK);

        // Length sweep.
        foreach (sweep[i]) drive_pulse(sweep[i], 6, 1'b1, low);
        check("sweep_no_drop", 32'(OUT_DROPPED), 32'd0);

        // Saturation and recovery, plus the boundary around the counter maximum.
        drive_pulse(40, 6, 1'b1, low);
        drive_pulse(4,  6, 1'b1, low);
        drive_pulse(31, 6, 1'b1, low);
        drive_pulse(32, 6, 1'b1, low);

        // Result held while the consumer stalls; a pulse during REPORT is dropped.
        IN_READY = 1'b0;
        drive_pulse(6, 4, 1'b1, low);
        drive_pulse(3, 4, 1'b0, low);
        check("hold_valid",   32'(OUT_VALID),             32'd1);
        check("hold_len",     32'(OUT_PULSE_LENGTH_CLKS), 32'd6);
        check("hold_dropped", 32'(OUT_DROPPED),           32'd1);
        IN_READY = 1'b1;
        @(negedge IN_CLOCK);
        check("hs_valid",    32'(OUT_VALID),             32'd0);
        check("hs_dropped",  32'(OUT_DROPPED),           32'd0);
        check("hs_overflow", 32'(OUT_OVERFLOW),          32'd0);
        check("hs_len_hold", 32'(OUT_PULSE_LENGTH_CLKS), 32'd6);
        repeat (4) @(negedge IN_CLOCK);

        // Reset in the middle of a 10-clock pulse aborts it.
        IN_PULSE = 1'b1;
        repeat (4) @(negedge IN_CLOCK);
        IN_RESET_N = 1'b0;
        @(negedge IN_CLOCK);
        IN_RESET_N = 1'b1;
        check("midrst_len",      32'(OUT_PULSE_LENGTH_CLKS), 32'd0);
        check("midrst_valid",    32'(OUT_VALID),             32'd0);
        check("midrst_overflow", 32'(OUT_OVERFLOW),          32'd0);
        check("midrst_dropped",  32'(OUT_DROPPED),           32'd0);
        repeat (5) @(negedge IN_CLOCK);
        IN_PULSE = 1'b0;
        repeat (6) @(negedge IN_CLOCK);
        drive_pulse(2, 6, 1'b1, low);

        // Back-to-back pulses: a 2-sample gap is measured, a 1-sample gap drops.
        drive_pulse(3, 2, 1'b1, low);
        drive_pulse(3, 1, 1'b1, low);
        drive_pulse(3, 6, 1'b0, low);
        check("gap1_dropped", 32'(OUT_DROPPED), 32'd1);
        check("gap1_valid",   32'(OUT_VALID),   32'd0);

        // Let any outstanding result arrive, bounded.
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge IN_CLOCK);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_length_meter
